// File: rtl/axi_lite_to_reg.sv
// AXI-Lite slave to single-beat register bus bridge, one access in flight.
// Ports: clk_i/rst_i, AXI-Lite AW/W/B/AR/R (in_*), register bus (reg_*).
// Optional build macro AXI_LITE_TO_REG_TIMEOUT_EN adds a REQ wait limit.
module axi_lite_to_reg #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] in_aw_addr,
  input  logic                      in_aw_valid,
  output logic                      in_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0] in_w_data,
  input  logic [AXI_STRB_WIDTH-1:0] in_w_strb,
  input  logic                      in_w_valid,
  output logic                      in_w_ready,
  output logic [1:0]                in_b_resp,
  output logic                      in_b_valid,
  input  logic                      in_b_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] in_ar_addr,
  input  logic                      in_ar_valid,
  output logic                      in_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0] in_r_data,
  output logic [1:0]                in_r_resp,
  output logic                      in_r_valid,
  input  logic                      in_r_ready,
  output logic                      reg_req_o,
  output logic                      reg_write_o,
  output logic [AXI_ADDR_WIDTH-1:0] reg_addr_o,
  output logic [AXI_DATA_WIDTH-1:0] reg_wdata_o,
  output logic [AXI_STRB_WIDTH-1:0] reg_wstrb_o,
  input  logic                      reg_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0] reg_rdata_i,
  input  logic                      reg_error_i
);

  typedef enum logic [1:0] {
    IDLE, REQ, BRESP, RRESP
  } state_e;

  state_e state_q, state_d;

  // 0: write wins a tie, 1: read wins
  logic prio_q, prio_d;

  logic                      req_q, req_d;
  logic                      wr_q, wr_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      rvalid_q, rvalid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic idle, wr_elig, rd_elig;
  logic grant_w, grant_r;
  logic tmo, done, err;

  assign idle    = (state_q == IDLE);
  assign wr_elig = in_aw_valid & in_w_valid;
  assign rd_elig = in_ar_valid;
  assign grant_w = idle & wr_elig & (~rd_elig | ~prio_q);
  assign grant_r = idle & rd_elig & (~wr_elig | prio_q);

  assign in_aw_ready = grant_w;
  assign in_w_ready  = grant_w;
  assign in_ar_ready = grant_r;

`ifdef AXI_LITE_TO_REG_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry acts like a completion carrying an error.
  assign tmo = (state_q == REQ) & ~reg_ready_i
             & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (grant_w | grant_r) begin
      cnt_d = '0;
    end else if ((state_q == REQ) & ~reg_ready_i & ~tmo) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES < 2);
  assign tmo = 1'b0;
`endif

  assign done = reg_ready_i | tmo;
  assign err  = reg_error_i | tmo;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    req_d    = req_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d = REQ;
          prio_d  = ~prio_q;
          req_d   = 1'b1;
          wr_d    = 1'b1;
          addr_d  = in_aw_addr;
          wdata_d = in_w_data;
          wstrb_d = in_w_strb;
        end else if (grant_r) begin
          state_d = REQ;
          prio_d  = ~prio_q;
          req_d   = 1'b1;
          wr_d    = 1'b0;
          addr_d  = in_ar_addr;
        end
      end
      REQ: begin
        if (done) begin
          req_d = 1'b0;
          if (wr_q) begin
            state_d  = BRESP;
            bvalid_d = 1'b1;
            bresp_d  = err ? 2'b10 : 2'b00;
          end else begin
            state_d  = RRESP;
            rvalid_d = 1'b1;
            rresp_d  = err ? 2'b10 : 2'b00;
            rdata_d  = tmo ? '0 : reg_rdata_i;
          end
        end
      end
      BRESP: begin
        if (in_b_ready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RRESP: begin
        if (in_r_ready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign reg_req_o   = req_q;
  assign reg_write_o = wr_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;
  assign in_b_valid  = bvalid_q;
  assign in_b_resp   = bresp_q;
  assign in_r_valid  = rvalid_q;
  assign in_r_resp   = rresp_q;
  assign in_r_data   = rdata_q;

endmodule

// File: tb/tb_axi_lite_to_reg.sv
// Self-checking bench for axi_lite_to_reg: directed and random
// single-channel accesses, contention order, reset and timeout.
module tb_axi_lite_to_reg;

  localparam int TO = 8;
  localparam logic [31:0] ERR_DATA = 32'hE0E0_E0E0;

  logic        clk;
  logic        rst_i;
  logic [31:0] in_aw_addr;
  logic        in_aw_valid, in_aw_ready;
  logic [31:0] in_w_data;
  logic [3:0]  in_w_strb;
  logic        in_w_valid, in_w_ready;
  logic [1:0]  in_b_resp;
  logic        in_b_valid, in_b_ready;
  logic [31:0] in_ar_addr;
  logic        in_ar_valid, in_ar_ready;
  logic [31:0] in_r_data;
  logic [1:0]  in_r_resp;
  logic        in_r_valid, in_r_ready;
  logic        reg_req_o, reg_write_o;
  logic [31:0] reg_addr_o, reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_ready_i, reg_error_i;
  logic [31:0] reg_rdata_i;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int bus_wait = 0;
  bit bus_err  = 0;
  int wcnt     = 0;

  logic [31:0] pmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  axi_lite_to_reg #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AXI_STRB_WIDTH(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_aw_addr(in_aw_addr), .in_aw_valid(in_aw_valid),
    .in_aw_ready(in_aw_ready),
    .in_w_data(in_w_data), .in_w_strb(in_w_strb),
    .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
    .in_b_resp(in_b_resp), .in_b_valid(in_b_valid),
    .in_b_ready(in_b_ready),
    .in_ar_addr(in_ar_addr), .in_ar_valid(in_ar_valid),
    .in_ar_ready(in_ar_ready),
    .in_r_data(in_r_data), .in_r_resp(in_r_resp),
    .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
    .reg_req_o(reg_req_o), .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i),
    .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pmem_rd(input logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Peripheral register file on the register bus.
  always @(negedge clk) begin
    reg_ready_i = 1'b0;
    reg_error_i = 1'b0;
    reg_rdata_i = '0;
    if (reg_req_o) begin
      if (wcnt < bus_wait) begin
        wcnt++;
      end else begin
        wcnt = 0;
        reg_ready_i = 1'b1;
        reg_error_i = bus_err;
        if (bus_err)
          reg_rdata_i = ERR_DATA;
        else if (reg_write_o)
          pmem[reg_addr_o] = merge(pmem_rd(reg_addr_o),
                                   reg_wdata_o, reg_wstrb_o);
        else
          reg_rdata_i = pmem_rd(reg_addr_o);
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One access on a single channel; wt = bus wait cycles,
  // er = bus error, rdly = cycles the B/R ready is held low,
  // lead = cycles AW is valid before W.
  task automatic xact(input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int wt, input bit er,
                      input int rdly, input int lead);
    int acc, lat;
    bit got, stab, tmo;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    string nm;
    nm = wr ? "wr" : "rd";
    bus_wait = wt;
    bus_err  = er;
    exp_r = er ? 2'b10 : 2'b00;
    lat   = 2 + wt;
    tmo   = 0;
`ifdef AXI_LITE_TO_REG_TIMEOUT_EN
    if (wt > TO - 1) begin
      lat = 2 + TO - 1;
      exp_r = 2'b10;
      tmo = 1;
    end
`endif
    exp_d = (er || tmo) ? ((er && !tmo) ? ERR_DATA : 32'h0)
                        : ref_rd(a);
    if (wr) begin
      in_aw_addr  = a;
      in_w_data   = d;
      in_w_strb   = s;
      in_aw_valid = 1'b1;
      stab = 1;
      for (int k = 0; k < lead; k++) begin
        #1;
        if (in_aw_ready || in_w_ready) stab = 0;
        @(negedge clk);
      end
      if (lead > 0) chk("aw_without_w_ready", 64'(stab), 64'd1);
      in_w_valid = 1'b1;
    end else begin
      in_ar_addr  = a;
      in_ar_valid = 1'b1;
    end
    got = 0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (wr ? in_aw_ready : in_ar_ready) begin
        got = 1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_accept"}, 64'(got), 64'd1);
    if (wr) chk("w_ready_pair", 64'(in_w_ready), 64'(in_aw_ready));
    @(negedge clk);
    in_aw_valid = 1'b0;
    in_w_valid  = 1'b0;
    in_ar_valid = 1'b0;
    chk({nm, "_req"}, 64'(reg_req_o), 64'd1);
    chk({nm, "_reg_write"}, 64'(reg_write_o), 64'(wr));
    chk({nm, "_reg_addr"}, 64'(reg_addr_o), 64'(a));
    if (wr) begin
      chk("wr_reg_wdata", 64'(reg_wdata_o), 64'(d));
      chk("wr_reg_wstrb", 64'(reg_wstrb_o), 64'(s));
    end
    stab = 1;
    got  = 0;
    for (int k = 0; k < 64; k++) begin
      if (wr ? in_b_valid : in_r_valid) begin
        got = 1;
        break;
      end
      if (!reg_req_o || reg_addr_o !== a || reg_write_o !== wr)
        stab = 0;
      if (wr && (reg_wdata_o !== d || reg_wstrb_o !== s))
        stab = 0;
      @(negedge clk);
    end
    chk({nm, "_resp_valid"}, 64'(got), 64'd1);
    chk({nm, "_reg_stable"}, 64'(stab), 64'd1);
    chk({nm, "_latency"}, 64'(cyc - acc), 64'(lat));
    chk({nm, "_req_drop"}, 64'(reg_req_o), 64'd0);
    if (wr) begin
      chk("b_resp", 64'(in_b_resp), 64'(exp_r));
      if (!er && !tmo) ref_mem[a] = merge(ref_rd(a), d, s);
    end else begin
      chk("r_resp", 64'(in_r_resp), 64'(exp_r));
      chk("r_data", 64'(in_r_data), 64'(exp_d));
    end
    stab = 1;
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      if (wr && (!in_b_valid || in_b_resp !== exp_r)) stab = 0;
      if (!wr && (!in_r_valid || in_r_resp !== exp_r
                  || in_r_data !== exp_d)) stab = 0;
    end
    if (rdly > 0) chk({nm, "_hold"}, 64'(stab), 64'd1);
    in_b_ready = wr;
    in_r_ready = !wr;
    @(negedge clk);
    in_b_ready = 1'b0;
    in_r_ready = 1'b0;
    chk({nm, "_valid_clear"},
        64'(wr ? in_b_valid : in_r_valid), 64'd0);
  endtask

  initial begin
    bit wr, er, pref_w, prev;
    int ng, pulses;
    logic [31:0] a, d;
    logic [3:0]  s;

    rst_i = 1'b1;
    in_aw_addr = '0; in_aw_valid = 0;
    in_w_data = '0;  in_w_strb = '0; in_w_valid = 0;
    in_b_ready = 0;
    in_ar_addr = '0; in_ar_valid = 0;
    in_r_ready = 0;
    pmem[32'h24]    = 32'h1234_5678;
    ref_mem[32'h24] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 64'(reg_req_o), 64'd0);
    chk("rst_bvalid", 64'(in_b_valid), 64'd0);
    chk("rst_rvalid", 64'(in_r_valid), 64'd0);
    chk("rst_addr", 64'(reg_addr_o), 64'd0);
    chk("rst_rdata", 64'(in_r_data), 64'd0);
    chk("rst_resp", 64'({in_b_resp, in_r_resp}), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    xact(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
    xact(0, 32'h24, 32'h0, 4'h0, 3, 0, 0, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0);
    xact(0, 32'h24, 32'h0, 4'h0, 0, 1, 5, 0);
    xact(1, 32'h18, 32'hCAFE_1234, 4'b0101, 1, 0, 2, 3);
    xact(0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 0);
    xact(1, 32'h1C, 32'h5555_AAAA, 4'hF, 0, 1, 5, 0);

    for (int i = 0; i < 14; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7)) << 2;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      er = ($urandom_range(0, 5) == 0);
      xact(wr, a, d, s, $urandom_range(0, 3), er,
           $urandom_range(0, 2), 0);
    end

`ifdef AXI_LITE_TO_REG_TIMEOUT_EN
    xact(1, 32'h50, 32'h1111_2222, 4'hF, 1000, 0, 0, 0);
    xact(0, 32'h54, 32'h0, 4'h0, 1000, 0, 1, 0);
`endif

    // Reset in the middle of a stalled access.
    bus_wait = 1000;
    bus_err  = 0;
    in_ar_addr  = 32'h30;
    in_ar_valid = 1'b1;
    @(negedge clk);
    in_ar_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_req_before", 64'(reg_req_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("midrst_req", 64'(reg_req_o), 64'd0);
    chk("midrst_addr", 64'(reg_addr_o), 64'd0);
    chk("midrst_rvalid", 64'(in_r_valid), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    bus_wait = 0;
    @(negedge clk);
    chk("midrst_idle_req", 64'(reg_req_o), 64'd0);

    // Write and read both held valid straight after reset.
    in_b_ready  = 1'b1;
    in_r_ready  = 1'b1;
    in_aw_addr  = 32'h40;
    in_w_data   = 32'h0BAD_F00D;
    in_w_strb   = 4'hF;
    in_ar_addr  = 32'h44;
    in_aw_valid = 1'b1;
    in_w_valid  = 1'b1;
    in_ar_valid = 1'b1;
    pref_w = 1;
    ng = 0;
    pulses = 0;
    prev = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      #1;
      if (reg_req_o && !prev) pulses++;
      prev = reg_req_o;
      if (in_aw_ready || in_ar_ready) begin
        chk($sformatf("grant%0d_w", ng), 64'(in_aw_ready),
            64'(pref_w));
        chk($sformatf("grant%0d_r", ng), 64'(in_ar_ready),
            64'(!pref_w));
        chk($sformatf("grant%0d_wpair", ng), 64'(in_w_ready),
            64'(in_aw_ready));
        pref_w = !pref_w;
        ng++;
      end
      @(negedge clk);
    end
    in_aw_valid = 1'b0;
    in_w_valid  = 1'b0;
    in_ar_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (reg_req_o && !prev) pulses++;
      prev = reg_req_o;
      @(negedge clk);
    end
    in_b_ready = 1'b0;
    in_r_ready = 1'b0;
    chk("grant_count", 64'(ng), 64'd4);
    chk("req_pulses", 64'(pulses), 64'd4);
    chk("drain_bvalid", 64'(in_b_valid), 64'd0);
    chk("drain_rvalid", 64'(in_r_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/axi_lite_to_reg.md
Name: axi_lite_to_reg

Overview:
- Terminates one AXI-Lite master port of the crossbar and converts each transaction into a single-beat request on a simple register bus that peripheral register files consume.
- One transaction is outstanding at a time.
- Read and write contention is resolved by round-robin.
- Register-bus errors map to SLVERR.

Parameters:
- AXI_ADDR_WIDTH, 32, width of the AXI-Lite and register-bus address.
- AXI_DATA_WIDTH, 32, data width, 32 or 64.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width.
- TIMEOUT_CYCLES, 256, register-bus wait limit; used only with the optional feature. Must be ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- in_aw_addr  in  AXI_ADDR_WIDTH  write address
- in_aw_valid / in_aw_ready  in/out  1  AW handshake
- in_w_data  in  AXI_DATA_WIDTH  write data
- in_w_strb  in  AXI_STRB_WIDTH  write strobes
- in_w_valid / in_w_ready  in/out  1  W handshake
- in_b_resp  out  2  write response
- in_b_valid / in_b_ready  out/in  1  B handshake
- in_ar_addr  in  AXI_ADDR_WIDTH  read address
- in_ar_valid / in_ar_ready  in/out  1  AR handshake
- in_r_data  out  AXI_DATA_WIDTH  read data
- in_r_resp  out  2  read response
- in_r_valid / in_r_ready  out/in  1  R handshake
- reg_req_o  out  1  register access request
- reg_write_o  out  1  1=write, 0=read
- reg_addr_o  out  AXI_ADDR_WIDTH  register address
- reg_wdata_o  out  AXI_DATA_WIDTH  write data
- reg_wstrb_o  out  AXI_STRB_WIDTH  write strobes
- reg_ready_i  in  1  access complete, sampled while reg_req_o=1
- reg_rdata_i  in  AXI_DATA_WIDTH  read data, valid with reg_ready_i
- reg_error_i  in  1  access error, valid with reg_ready_i

Behaviour:
- All outputs are registered.
- On rst_i all valid, ready and req outputs are 0. All data, address and resp outputs are 0. FSM is in IDLE. Priority flag prefers write.
- FSM states: IDLE, REQ, BRESP, RRESP.
- Write is eligible only when in_aw_valid=1 and in_w_valid=1. AW and W are accepted in the same cycle; in_aw_ready and in_w_ready are always asserted together.
- Read is eligible when in_ar_valid=1.
- IDLE, one candidate eligible: assert that channel's ready(s) combinationally from registered state, for exactly one cycle. Latch addr/data/strb. Go to REQ next cycle with reg_req_o=1.
- IDLE, both eligible: grant the channel named by the priority flag. Toggle the flag after every grant.
- REQ: hold reg_req_o and all reg_* outputs stable until reg_ready_i=1.
  - Next cycle: reg_req_o=0.
  - Write goes to BRESP with in_b_valid=1.
  - Read goes to RRESP with in_r_valid=1 and in_r_data = captured reg_rdata_i.
  - resp = 2'b10 (SLVERR) if reg_error_i=1, else 2'b00 (OKAY).
- Latency, zero-wait register bus: accept at cycle N, reg_req_o at N+1, b/r_valid at N+2 if reg_ready_i=1 at N+1.
- BRESP/RRESP: hold valid, resp and data until the ready handshake, then return to IDLE. No new accept in the same cycle as the B/R handshake; the next accept is no earlier than one cycle later.
- AW valid without W (or W without AW): never accepted; no deadlock with reads, since AR remains eligible.
- Reset mid-transaction: the transaction is dropped and all outputs return to reset values immediately (asynchronous reset).
- Address is passed unmodified; no alignment check.

Optional Feature:
AXI_LITE_TO_REG_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each REQ cycle with reg_ready_i=0. If it reaches TIMEOUT_CYCLES-1 without reg_ready_i, the FSM leaves REQ next cycle exactly as if reg_ready_i=1 and reg_error_i=1: resp=SLVERR, r_data=0.
- Not defined: no counter is instantiated and REQ waits indefinitely.

Test Plan:
- Write, zero-wait bus: aw_addr=0x10, w_data=0xDEADBEEF, strb=0xF → reg_write_o=1, reg_addr_o=0x10, reg_wdata_o=0xDEADBEEF, reg_wstrb_o=0xF. b_valid 2 cycles after accept, b_resp=00.
- Read with 3 wait cycles: ar_addr=0x24, reg_ready_i after 3 cycles with rdata=0x12345678 → r_data=0x12345678, r_resp=00. reg_* stable throughout.
- Simultaneous AW+W and AR held valid for 4 transactions after reset → grant order W,R,W,R. Exactly one reg_req_o pulse train per transaction.
- reg_error_i=1 on a read → r_resp=10. B/R valid held until r_ready; r_ready held low 5 cycles → data and resp unchanged.
- AW valid for 3 cycles before W → aw_ready=0 until w_valid=1, then aw_ready and w_ready assert together for one cycle.
- With AXI_LITE_TO_REG_TIMEOUT_EN, TIMEOUT_CYCLES=8, reg_ready_i tied 0 → b_valid with b_resp=10 after 8 REQ cycles. Assert rst_i mid-REQ on a second access → reg_req_o=0 immediately.
